window_7x7_sequencer: RTL and testbench

WINDOW_7X7_SEQUENCER -- requirements
Module: window_7x7_sequencer

---
 rtl/window_7x7_sequencer.sv | 122 ++++++++++++
 tb/tb_window_7x7_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/window_7x7_sequencer.sv
// window_7x7_sequencer: sequences line-buffer shifts and 7x7 window centers over a raster frame.
// Optional border masks are enabled by defining WIN7_BORDER_MASK_EN.
module window_7x7_sequencer #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       valid_i,
  output logic       shift_en_o,
  output logic       window_valid_o,
  output logic [9:0] row_o,
  output logic [9:0] col_o,
  output logic [6:0] row_mask_o,
  output logic [6:0] col_mask_o,
  output logic       busy_o,
  output logic       done_o
);
  localparam int FILL_N = 3 * IMG_W + 3;
  localparam int TOTAL = IMG_W * IMG_H;
  localparam int CW = $clog2(TOTAL + 1);
  typedef enum logic [2:0] {IDLE, FILL, RUN, FLUSH, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [9:0] nrow_q, nrow_d, ncol_q, ncol_d, row_q, col_q;
  logic wv_q, emit, col_wrap;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    shift_en_o = 1'b0;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = FILL;
        cnt_d = '0;
      end
      FILL: if (valid_i) begin
        shift_en_o = 1'b1;
        cnt_d = cnt_q + 1'b1;
        state_d = (cnt_d == CW'(FILL_N)) ? RUN : FILL;
      end
      RUN: if (valid_i) begin
        shift_en_o = 1'b1;
        cnt_d = cnt_q + 1'b1;
        state_d = (cnt_d == CW'(TOTAL)) ? FLUSH : RUN;
        cnt_d = (cnt_d == CW'(TOTAL)) ? '0 : cnt_d;
      end
      FLUSH: begin
        shift_en_o = 1'b1;
        cnt_d = cnt_q + 1'b1;
        state_d = (cnt_d == CW'(FILL_N)) ? DONE : FLUSH;
      end
      default: state_d = IDLE;
    endcase
  end
  // ncol/nrow track the center of the next window to be emitted
  assign emit = shift_en_o && (state_q == RUN || state_q == FLUSH);
  assign col_wrap = ncol_q == 10'(IMG_W - 1);
  always_comb begin
    ncol_d = ncol_q;
    nrow_d = nrow_q;
    if (state_q == IDLE && start_i) begin
      ncol_d = '0;
      nrow_d = '0;
    end else if (emit) begin
      ncol_d = col_wrap ? 10'd0 : ncol_q + 10'd1;
      nrow_d = (col_wrap && nrow_q != 10'(IMG_H - 1)) ? nrow_q + 10'd1 : nrow_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      nrow_q <= '0;
      ncol_q <= '0;
      wv_q <= 1'b0;
      row_q <= '0;
      col_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      nrow_q <= nrow_d;
      ncol_q <= ncol_d;
      wv_q <= emit;
      if (emit) begin
        row_q <= nrow_q;
        col_q <= ncol_q;
      end
    end
  end
`ifdef WIN7_BORDER_MASK_EN
  logic [6:0] rmask_d, cmask_d, rmask_q, cmask_q;
  // tap k sits at center-3+k; offsetting by +3 keeps the range test unsigned
  always_comb begin
    rmask_d = '0;
    cmask_d = '0;
    for (int k = 0; k < 7; k++) begin
      rmask_d[k] = ({1'b0, nrow_q} + 11'(k)) >= 11'd3 && ({1'b0, nrow_q} + 11'(k)) <= 11'(IMG_H + 2);
      cmask_d[k] = ({1'b0, ncol_q} + 11'(k)) >= 11'd3 && ({1'b0, ncol_q} + 11'(k)) <= 11'(IMG_W + 2);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rmask_q <= 7'h7F;
      cmask_q <= 7'h7F;
    end else if (emit) begin
      rmask_q <= rmask_d;
      cmask_q <= cmask_d;
    end
  end
  assign row_mask_o = rmask_q;
  assign col_mask_o = cmask_q;
`else
  assign row_mask_o = 7'h7F;
  assign col_mask_o = 7'h7F;
`endif
  assign window_valid_o = wv_q;
  assign row_o = row_q;
  assign col_o = col_q;
  assign busy_o = state_q != IDLE;
  assign done_o = state_q == DONE;
endmodule

// File: tb/tb_window_7x7_sequencer.sv
// tb_window_7x7_sequencer: scoreboard bench for the 7x7 window sequencer at 8x6.
module tb_window_7x7_sequencer;
  localparam int W = 8;
  localparam int H = 6;
  logic clk = 1'b0;
  logic rst, start_i, valid_i;
  logic shift_en_o, window_valid_o, busy_o, done_o;
  logic [9:0] row_o, col_o;
  logic [6:0] row_mask_o, col_mask_o;
  int errors = 0;
  int checks = 0;
  int win_cnt = 0;
  typedef struct {
    logic [9:0] row;
    logic [9:0] col;
    logic [6:0] rm;
    logic [6:0] cm;
  } exp_t;
  exp_t sb[$];

  window_7x7_sequencer #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .valid_i(valid_i),
    .shift_en_o(shift_en_o), .window_valid_o(window_valid_o),
    .row_o(row_o), .col_o(col_o), .row_mask_o(row_mask_o), .col_mask_o(col_mask_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] exp_mask(input int c, input int lim);
    logic [6:0] m;
    m = 7'h7F;
`ifdef WIN7_BORDER_MASK_EN
    for (int k = 0; k < 7; k++) m[k] = (c - 3 + k >= 0) && (c - 3 + k < lim);
`endif
    return m;
  endfunction

  always @(negedge clk) begin
    if (window_valid_o) begin
      exp_t e;
      win_cnt++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_window got row=%0d col=%0d", row_o, col_o);
      end else begin
        e = sb.pop_front();
        if ({row_o, col_o, row_mask_o, col_mask_o} !== {e.row, e.col, e.rm, e.cm}) begin
          errors++;
          $display("FAIL window got row=%0d col=%0d rm=%b cm=%b expected row=%0d col=%0d rm=%b cm=%b",
                   row_o, col_o, row_mask_o, col_mask_o, e.row, e.col, e.rm, e.cm);
        end
      end
    end
  end

  // Drives one frame and gathers observations; the calling tests judge them.
  task automatic drive_frame(input int gap_pct, input bit hold, output int first_win,
                             output int bad_shift, output int flush_n, output int done_cnt,
                             output int busy_cnt, output int idle_shift, output int wins);
    int sent, g, w0;
    bit v;
    w0 = win_cnt;
    first_win = -1;
    bad_shift = 0;
    flush_n = 0;
    done_cnt = 0;
    busy_cnt = 0;
    idle_shift = 0;
    @(negedge clk);
    start_i = 1'b1;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        sb.push_back('{row: 10'(r), col: 10'(c), rm: exp_mask(r, H), cm: exp_mask(c, W)});
    @(negedge clk);
    start_i = hold;
    sent = 0;
    g = 0;
    while (sent < W * H && g < 2000) begin
      if (window_valid_o && first_win < 0) first_win = sent;
      v = $urandom_range(0, 99) >= gap_pct;
      valid_i = v;
      #1;
      if (shift_en_o !== v) bad_shift++;
      if (v) sent++;
      @(negedge clk);
      g++;
    end
    valid_i = hold;
    g = 0;
    while (done_o !== 1'b1 && g < 300) begin
      if (window_valid_o && first_win < 0) first_win = sent;
      if (shift_en_o) flush_n++;
      @(negedge clk);
      g++;
    end
    done_cnt = (done_o === 1'b1) ? 1 : 0;
    start_i = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      if (shift_en_o) idle_shift++;
      if (done_o) done_cnt++;
      if (busy_o) busy_cnt++;
      @(negedge clk);
    end
    valid_i = 1'b0;
    wins = win_cnt - w0;
  endtask

  task automatic check_frame(input string tag, input int gap_pct, input bit hold);
    int first_win, bad_shift, flush_n, done_cnt, busy_cnt, idle_shift, wins;
    drive_frame(gap_pct, hold, first_win, bad_shift, flush_n, done_cnt, busy_cnt, idle_shift, wins);
    checks += 8;
    if (first_win !== 28) begin errors++; $display("FAIL %s first_window got=%0d expected=28", tag, first_win); end
    if (bad_shift !== 0) begin errors++; $display("FAIL %s shift_vs_valid got=%0d expected=0", tag, bad_shift); end
    if (flush_n !== 27) begin errors++; $display("FAIL %s flush_len got=%0d expected=27", tag, flush_n); end
    if (done_cnt !== 1) begin errors++; $display("FAIL %s done_pulses got=%0d expected=1", tag, done_cnt); end
    if (busy_cnt !== 0) begin errors++; $display("FAIL %s busy_after_done got=%0d expected=0", tag, busy_cnt); end
    if (idle_shift !== 0) begin errors++; $display("FAIL %s idle_shift got=%0d expected=0", tag, idle_shift); end
    if (wins !== W * H) begin errors++; $display("FAIL %s windows got=%0d expected=%0d", tag, wins, W * H); end
    if (sb.size() !== 0) begin errors++; $display("FAIL %s leftover got=%0d expected=0", tag, sb.size()); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_i = 1'b0;
    valid_i = 1'b1;
    repeat (2) @(negedge clk);
    checks += 7;
    if (window_valid_o !== 1'b0) begin errors++; $display("FAIL rst_wv got=%b expected=0", window_valid_o); end
    if (done_o !== 1'b0) begin errors++; $display("FAIL rst_done got=%b expected=0", done_o); end
    if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b expected=0", busy_o); end
    if ({row_o, col_o} !== 20'd0) begin errors++; $display("FAIL rst_pos got=%0d,%0d expected=0,0", row_o, col_o); end
    if (row_mask_o !== 7'h7F) begin errors++; $display("FAIL rst_rmask got=%b expected=1111111", row_mask_o); end
    if (col_mask_o !== 7'h7F) begin errors++; $display("FAIL rst_cmask got=%b expected=1111111", col_mask_o); end
    if (shift_en_o !== 1'b0) begin errors++; $display("FAIL rst_shift got=%b expected=0", shift_en_o); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (shift_en_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_valid_ignored got shift=%b busy=%b expected 0 0", shift_en_o, busy_o);
    end
    valid_i = 1'b0;
  endtask

  task automatic test_midframe_reset();
    int dn, bz;
    @(negedge clk);
    start_i = 1'b1;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        sb.push_back('{row: 10'(r), col: 10'(c), rm: exp_mask(r, H), cm: exp_mask(c, W)});
    @(negedge clk);
    start_i = 1'b0;
    for (int i = 0; i < 30; i++) begin
      valid_i = 1'b1;
      @(negedge clk);
    end
    valid_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    checks += 3;
    if (window_valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_flags got wv=%b busy=%b done=%b expected 0 0 0", window_valid_o, busy_o, done_o);
    end
    if ({row_o, col_o} !== 20'd0) begin errors++; $display("FAIL abort_pos got=%0d,%0d expected=0,0", row_o, col_o); end
    if ({row_mask_o, col_mask_o} !== 14'h3FFF) begin
      errors++;
      $display("FAIL abort_masks got=%b %b expected all ones", row_mask_o, col_mask_o);
    end
    dn = 0;
    bz = 0;
    valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (done_o) dn++;
      if (busy_o || shift_en_o) bz++;
      @(negedge clk);
    end
    valid_i = 1'b0;
    checks += 2;
    if (dn !== 0) begin errors++; $display("FAIL abort_done got=%0d expected=0", dn); end
    if (bz !== 0) begin errors++; $display("FAIL abort_needs_start got=%0d expected=0", bz); end
    check_frame("after_abort", 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    check_frame("back_to_back", 0, 1'b0);
  endtask

  task automatic test_gapped();
    check_frame("gapped", 50, 1'b0);
  endtask

  task automatic test_start_held();
    check_frame("start_held", 0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gapped();
    test_midframe_reset();
    test_start_held();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
